// File: rtl/program_mem_ctrl.sv
// Program-memory fetch arbiter: serves one core fetch at a time through a single memory read port,
// round-robin across cores, with per-core response registers and a one-cycle ready pulse.
module program_mem_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           core_req_valid,
  input  logic [NUM_CORES*ADDR_BITS-1:0] core_req_addr,
  output logic [NUM_CORES-1:0]           core_req_ready,
  output logic [NUM_CORES*DATA_BITS-1:0] core_rsp_data,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_addr,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data
);

  localparam int ID_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [ID_BITS-1:0]             grant_q, grant_d;
  logic [ID_BITS-1:0]             rr_ptr_q, rr_ptr_d;
  logic [ADDR_BITS-1:0]           addr_q, addr_d;
  logic [NUM_CORES-1:0]           done_mask_q, done_mask_d;
  logic [NUM_CORES-1:0]           set_mask;
  logic [NUM_CORES*DATA_BITS-1:0] rsp_q, rsp_d;

  logic               found;
  logic [ID_BITS-1:0] pick;
  int unsigned        idx;

  // Circular search for the first eligible core starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_CORES;
      if (!found && core_req_valid[idx] && !done_mask_q[idx]) begin
        found = 1'b1;
        pick  = ID_BITS'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    rr_ptr_d = rr_ptr_q;
    rsp_d    = rsp_q;
    set_mask = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          addr_d  = core_req_addr[pick*ADDR_BITS +: ADDR_BITS];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_read_ready) begin
          rsp_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          state_d = DONE;
        end
      end
      DONE: begin
        set_mask[grant_q] = 1'b1;
        rr_ptr_d = (grant_q == ID_BITS'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A dropped valid always clears the completion mark, even on the completing edge.
    done_mask_d = core_req_valid & (done_mask_q | set_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      done_mask_q <= '0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      done_mask_q <= done_mask_d;
      rsp_q       <= rsp_d;
    end
  end

  assign mem_read_valid = (state_q == ISSUE);
  assign mem_read_addr  = addr_q;
  assign core_req_ready = (state_q == DONE) ? (NUM_CORES'(1) << grant_q) : '0;
  assign core_rsp_data  = rsp_q;

endmodule

// File: tb/tb_program_mem_ctrl.sv
// Bench for program_mem_ctrl: directed scenarios plus random traffic, checked each cycle
// against a transaction-level reference model of the arbiter.
module tb_program_mem_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_req_valid;
  logic [N*8-1:0] core_req_addr;
  logic [N-1:0]  core_req_ready;
  logic [N*8-1:0] core_rsp_data;
  logic          mem_read_valid;
  logic [7:0]    mem_read_addr;
  logic          mem_read_ready;
  logic [7:0]    mem_read_data;

  logic [7:0] mem_arr [256];
  assign mem_read_data = mem_arr[mem_read_addr];

  program_mem_ctrl #(.NUM_CORES(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_req_valid (core_req_valid),
    .core_req_addr  (core_req_addr),
    .core_req_ready (core_req_ready),
    .core_rsp_data  (core_rsp_data),
    .mem_read_valid (mem_read_valid),
    .mem_read_addr  (mem_read_addr),
    .mem_read_ready (mem_read_ready),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 waiting, 1 memory outstanding, 2 completion pulse.
  int         m_phase, m_grant, m_ptr;
  logic [7:0] m_addr;
  bit         m_served [N];
  logic [7:0] m_rsp [N];

  int pulses [N];
  int grants [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_grant = 0; m_ptr = 0; m_addr = '0;
    for (int i = 0; i < N; i++) begin
      m_served[i] = 1'b0;
      m_rsp[i] = '0;
    end
  endtask

  task automatic model_update();
    bit nxt [N];
    bit got;
    for (int i = 0; i < N; i++)
      nxt[i] = core_req_valid[i] && (m_served[i] || (m_phase == 2 && m_grant == i));
    case (m_phase)
      0: begin
        got = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!got && core_req_valid[c] && !m_served[c]) begin
            got = 1'b1;
            m_grant = c;
            m_addr = core_req_addr[c*8 +: 8];
            m_phase = 1;
          end
        end
      end
      1: if (mem_read_ready) begin
        m_rsp[m_grant] = mem_arr[m_addr];
        m_phase = 2;
      end
      default: begin
        m_ptr = (m_grant + 1) % N;
        m_phase = 0;
      end
    endcase
    for (int i = 0; i < N; i++) m_served[i] = nxt[i];
  endtask

  task automatic check_outputs();
    logic [N*8-1:0] exp_rsp;
    logic [N-1:0]   exp_rdy;
    for (int i = 0; i < N; i++) exp_rsp[i*8 +: 8] = m_rsp[i];
    exp_rdy = (m_phase == 2) ? (N'(1) << m_grant) : '0;
    chk("mem_read_valid", 64'(mem_read_valid), 64'(m_phase == 1));
    chk("core_req_ready", 64'(core_req_ready), 64'(exp_rdy));
    if (m_phase == 1) chk("mem_read_addr", 64'(mem_read_addr), 64'(m_addr));
    chk("core_rsp_data", 64'(core_rsp_data), 64'(exp_rsp));
    for (int i = 0; i < N; i++)
      if (core_req_ready[i]) begin
        pulses[i]++;
        grants.push_back(i);
      end
  endtask

  // Called at a negedge: check this cycle, advance one clock edge, return at the next negedge.
  task automatic step();
    check_outputs();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_req_valid = '0;
    mem_read_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    core_req_valid = '0;
    core_req_addr = '0;
    mem_read_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    for (int i = 0; i < N; i++) pulses[i] = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 64'(mem_read_valid), 64'd0);
    chk("rst_addr", 64'(mem_read_addr), 64'd0);
    chk("rst_ready", 64'(core_req_ready), 64'd0);
    chk("rst_rsp", 64'(core_rsp_data), 64'd0);

    // Core 2 single fetch at minimum latency
    mem_arr[8'h10] = 8'hA5;
    core_req_addr[23:16] = 8'h10;
    core_req_valid = 4'b0100;
    mem_read_ready = 1'b1;
    step();
    chk("t1_valid", 64'(mem_read_valid), 64'd1);
    chk("t1_addr", 64'(mem_read_addr), 64'h10);
    step();
    chk("t1_ready", 64'(core_req_ready), 64'b0100);
    chk("t1_slot", 64'(core_rsp_data[23:16]), 64'hA5);
    core_req_valid = '0;
    step();
    step();

    // All four cores at once from a fresh reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      core_req_addr[i*8 +: 8] = 8'(i);
      mem_arr[i] = 8'hC0 + 8'(i);
    end
    grants.delete();
    core_req_valid = 4'hF;
    mem_read_ready = 1'b1;
    for (int t = 0; t < 40 && grants.size() < 4; t++) step();
    for (int t = 0; t < 6; t++) step();
    chk("t2_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("t2_order", 64'(grants[i]), 64'(i));
    for (int i = 0; i < N; i++) chk("t2_slot", 64'(core_rsp_data[i*8 +: 8]), 64'hC0 + 64'(i));
    core_req_valid = '0;
    step();

    // Memory stalls five cycles
    core_req_addr[31:24] = 8'h20;
    mem_arr[8'h20] = 8'h5A;
    core_req_valid = 4'b1000;
    mem_read_ready = 1'b0;
    step();
    for (int t = 0; t < 5; t++) begin
      chk("t3_hold_valid", 64'(mem_read_valid), 64'd1);
      chk("t3_hold_addr", 64'(mem_read_addr), 64'h20);
      chk("t3_no_ready", 64'(core_req_ready), 64'd0);
      step();
    end
    mem_read_ready = 1'b1;
    step();
    chk("t3_ready", 64'(core_req_ready), 64'b1000);
    chk("t3_slot", 64'(core_rsp_data[31:24]), 64'h5A);
    core_req_valid = '0;
    step();

    // Core 1 held valid is served once, then again after a low cycle
    pulses[1] = 0;
    core_req_addr[15:8] = 8'h31;
    core_req_valid = 4'b0010;
    for (int t = 0; t < 12; t++) step();
    chk("t4_once", 64'(pulses[1]), 64'd1);
    core_req_valid = '0;
    step();
    core_req_valid = 4'b0010;
    for (int t = 0; t < 10 && pulses[1] < 2; t++) step();
    chk("t4_again", 64'(pulses[1]), 64'd2);
    core_req_valid = '0;
    step();

    // Reset during ISSUE discards the transaction
    pulses[2] = 0;
    core_req_addr[23:16] = 8'h40;
    core_req_valid = 4'b0100;
    mem_read_ready = 1'b0;
    step();
    chk("t5_in_issue", 64'(mem_read_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(mem_read_valid), 64'd0);
    chk("t5_rst_addr", 64'(mem_read_addr), 64'd0);
    chk("t5_rst_ready", 64'(core_req_ready), 64'd0);
    chk("t5_rst_rsp", 64'(core_rsp_data), 64'd0);
    core_req_valid = '0;
    mem_read_ready = 1'b1;
    @(posedge clk);
    #1 chk("t5_no_pulse", 64'(core_req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    core_req_valid = 4'b0100;
    for (int t = 0; t < 10 && pulses[2] < 1; t++) step();
    chk("t5_after", 64'(pulses[2]), 64'd1);
    chk("t5_slot", 64'(core_rsp_data[23:16]), 64'(mem_arr[8'h40]));
    core_req_valid = '0;
    step();

    // Core 0 drops valid mid-ISSUE
    core_req_addr[7:0] = 8'h44;
    core_req_valid = 4'b0001;
    mem_read_ready = 1'b0;
    step();
    core_req_valid = '0;
    step();
    mem_read_ready = 1'b1;
    step();
    chk("t6_ready", 64'(core_req_ready), 64'b0001);
    chk("t6_slot", 64'(core_rsp_data[7:0]), 64'(mem_arr[8'h44]));
    step();

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (core_req_valid[i]) begin
          if ($urandom_range(7) == 0) core_req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          core_req_valid[i] = 1'b1;
          core_req_addr[i*8 +: 8] = 8'($urandom);
        end
      end
      mem_read_ready = ($urandom_range(1) == 1);
      step();
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
